// File: rtl/satd_nxn_if.sv
// satd_nxn_if: row-streaming handshake bundle between block fetcher, SATD engine and cost comparator.
interface satd_nxn_if #(
  parameter int N = 4,
  parameter int BITS = 8
);
  localparam int LOG2N = $clog2(N);
  localparam int RES_W = BITS + 3*LOG2N + 1;
  logic init;
  logic ack;
  logic in_valid;
  logic in_ready;
  logic done;
  logic [N*BITS-1:0] a_row;
  logic [N*BITS-1:0] b_row;
  logic [RES_W-1:0] result;
  modport master (
    output init, ack, in_valid, a_row, b_row,
    input  in_ready, result, done
  );
  modport slave (
    input  init, ack, in_valid, a_row, b_row,
    output in_ready, result, done
  );
endinterface

// File: rtl/satd_nxn.sv
// satd_nxn: row-serial NxN (4/8) Hadamard SATD engine; define SATD_NORM_EN for codec-normalised result.
module satd_nxn #(
  parameter int N = 4,
  parameter int BITS = 8
) (
  input logic clk,
  input logic reset,
  satd_nxn_if.slave bus
);
  localparam int LOG2N = $clog2(N);
  localparam int RES_W = BITS + 3*LOG2N + 1;
  localparam int RW = BITS + 1 + LOG2N;
  localparam int CW = BITS + 1 + 2*LOG2N;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] COL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (N != 4 && N != 8) begin : g_bad_n
    $error("satd_nxn: N must be 4 or 8");
  end
  if (BITS < 8 || BITS > 12) begin : g_bad_bits
    $error("satd_nxn: BITS must be in 8..12");
  end

  logic [1:0] state_q, state_d;
  logic [LOG2N-1:0] row_q, row_d;
  logic [LOG2N-1:0] col_q, col_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic done_q, done_d;
  logic signed [RW-1:0] tbuf_q [N][N];
  logic signed [CW-1:0] rs [LOG2N+1][N];
  logic signed [CW-1:0] cs [LOG2N+1][N];
  logic [CW-1:0] mag;
  logic [RES_W-1:0] col_sum;
  logic [RES_W-1:0] acc_sum;
  logic [RES_W-1:0] res_next;

  assign bus.in_ready = state_q == LOAD;
  assign bus.done = done_q;
  assign bus.result = res_q;

  // Both butterflies run at column width; row outputs are narrowed when stored.
  always_comb begin
    rs = '{default: '0};
    cs = '{default: '0};
    mag = '0;
    col_sum = '0;
    for (int j = 0; j < N; j++) begin
      rs[0][j] = CW'($signed({1'b0, bus.a_row[j*BITS +: BITS]}) - $signed({1'b0, bus.b_row[j*BITS +: BITS]}));
      cs[0][j] = CW'(tbuf_q[j][col_q]);
    end
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < N; j++) begin
        rs[s+1][j] = ((j & (1 << s)) != 0) ? rs[s][j ^ (1 << s)] - rs[s][j] : rs[s][j] + rs[s][j ^ (1 << s)];
        cs[s+1][j] = ((j & (1 << s)) != 0) ? cs[s][j ^ (1 << s)] - cs[s][j] : cs[s][j] + cs[s][j ^ (1 << s)];
      end
    end
    for (int j = 0; j < N; j++) begin
      mag = cs[LOG2N][j][CW-1] ? CW'(-cs[LOG2N][j]) : cs[LOG2N][j];
      col_sum = col_sum + RES_W'(mag);
    end
  end

  assign acc_sum = acc_q + col_sum;

`ifdef SATD_NORM_EN
  assign res_next = (acc_sum + (RES_W'(1) << (LOG2N - 2))) >> (LOG2N - 1);
`else
  assign res_next = acc_sum;
`endif

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    acc_d = acc_q;
    res_d = res_q;
    done_d = done_q;
    case (state_q)
      IDLE: begin
        state_d = bus.init ? LOAD : IDLE;
        acc_d = bus.init ? '0 : acc_q;
        row_d = bus.init ? '0 : row_q;
      end
      LOAD: begin
        row_d = bus.in_valid ? row_q + LOG2N'(1) : row_q;
        state_d = (bus.in_valid && row_q == LOG2N'(N - 1)) ? COL : LOAD;
        col_d = '0;
      end
      COL: begin
        acc_d = acc_sum;
        col_d = col_q + LOG2N'(1);
        state_d = (col_q == LOG2N'(N - 1)) ? DONE : COL;
        done_d = col_q == LOG2N'(N - 1);
        res_d = (col_q == LOG2N'(N - 1)) ? res_next : res_q;
      end
      default: begin
        state_d = bus.ack ? (bus.init ? LOAD : IDLE) : DONE;
        done_d = !bus.ack;
        acc_d = bus.ack ? '0 : acc_q;
        row_d = bus.ack ? '0 : row_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      acc_q <= acc_d;
      res_q <= res_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.in_valid) begin
      for (int j = 0; j < N; j++) tbuf_q[row_q][j] <= RW'(rs[LOG2N][j]);
    end
  end
endmodule
